// File: rtl/alu_control_mc.sv
// ALU control decode plus the multi-cycle MULT sequencer (stall, multiplier start, HI/LO write).
// Optional sticky illegal-funct detection is built when ALU_CTRL_ILLEGAL_EN is defined.
module alu_control_mc #(
  parameter int MULT_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       valid,
  input  logic       flush,
  input  logic [5:0] function_field,
  input  logic [1:0] alu_op,
  output logic [3:0] alu_control,
  output logic       mult_start,
  output logic       stall,
  output logic       hilo_we,
  output logic       illegal_funct
);

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_MULT = 6'b011000;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_MULT = 4'd14;

  // Counter preload for the BUSY phase; unused when MULT_CYCLES==1.
  localparam logic [CNT_W-1:0] CNT_INIT = (MULT_CYCLES > 1) ? CNT_W'(MULT_CYCLES - 2) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       decoded;
  logic             is_mult;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    decoded = OP_AND;
    unique case (alu_op)
      2'd0: decoded = OP_ADD;
      2'd1: decoded = OP_SUB;
      2'd3: decoded = OP_SLT;
      default: begin
        case (function_field)
          F_ADD:   decoded = OP_ADD;
          F_SUB:   decoded = OP_SUB;
          F_AND:   decoded = OP_AND;
          F_OR:    decoded = OP_OR;
          F_NOR:   decoded = OP_NOR;
          F_SLT:   decoded = OP_SLT;
          F_SLL:   decoded = OP_SLL;
          F_SRL:   decoded = OP_SRL;
          F_MULT:  decoded = OP_MULT;
          default: decoded = OP_AND;
        endcase
      end
    endcase
  end

  assign is_mult = valid & ~flush & (alu_op == 2'd2) & (function_field == F_MULT);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mult_start = 1'b0;
    stall      = 1'b0;
    hilo_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_mult) begin
          mult_start = 1'b1;
          stall      = 1'b1;
          if (MULT_CYCLES == 1) begin
            state_nxt = DONE;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (flush) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE: begin
        // A squashed MULT must not update HI/LO; no restart from here either way.
        hilo_we   = ~flush;
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign alu_control = (state == IDLE) ? decoded : OP_MULT;

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_EN
  logic funct_known;

  assign funct_known = function_field inside {F_ADD, F_SUB, F_AND, F_OR, F_NOR,
                                              F_SLT, F_SLL, F_SRL, F_MULT};

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      illegal_funct <= 1'b0;
    end else if (valid && !flush && alu_op == 2'd2 && !funct_known) begin
      illegal_funct <= 1'b1;
    end
  end
`else
  assign illegal_funct = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed bench for alu_control_mc: decode table, MULT sequencing (4-cycle and 1-cycle
// instances), flush, async reset and the optional illegal-funct flag.
module tb_alu_control_mc;

  logic       clk = 1'b0;
  logic       arst;
  logic       valid;
  logic       flush;
  logic [5:0] funct;
  logic [1:0] alu_op;

  logic [3:0] a_alu, b_alu;
  logic       a_start, b_start, a_stall, b_stall, a_we, b_we, a_ill, b_ill;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_BAD  = 6'b111111;
`ifdef ALU_CTRL_ILLEGAL_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  alu_control_mc #(.MULT_CYCLES(4), .CNT_W(4)) dut_a (
    .clk(clk), .arst(arst), .valid(valid), .flush(flush),
    .function_field(funct), .alu_op(alu_op), .alu_control(a_alu),
    .mult_start(a_start), .stall(a_stall), .hilo_we(a_we), .illegal_funct(a_ill)
  );

  alu_control_mc #(.MULT_CYCLES(1), .CNT_W(4)) dut_b (
    .clk(clk), .arst(arst), .valid(valid), .flush(flush),
    .function_field(funct), .alu_op(alu_op), .alu_control(b_alu),
    .mult_start(b_start), .stall(b_stall), .hilo_we(b_we), .illegal_funct(b_ill)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      valid = 1'b0; flush = 1'b0; alu_op = 2'd0; funct = 6'd0;
    end
  endtask

  task automatic test_reset();
    arst = 1'b1; valid = 1'b0; flush = 1'b0; alu_op = 2'd0; funct = 6'd0;
    #12;
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall_a: got %b want 0", a_stall); end
    n_cmp++; if (a_start !== 1'b0) begin n_err++; $display("FAIL reset_start_a: got %b want 0", a_start); end
    n_cmp++; if (a_we !== 1'b0) begin n_err++; $display("FAIL reset_we_a: got %b want 0", a_we); end
    n_cmp++; if (a_ill !== 1'b0) begin n_err++; $display("FAIL reset_ill_a: got %b want 0", a_ill); end
    n_cmp++; if (a_alu !== 4'd2) begin n_err++; $display("FAIL reset_alu_a: got %0d want 2", a_alu); end
    n_cmp++; if (b_we !== 1'b0 || b_stall !== 1'b0) begin n_err++; $display("FAIL reset_b: got we=%b stall=%b want 0/0", b_we, b_stall); end
    @(negedge clk);
    arst = 1'b0;
    go_idle(2);
  endtask

  task automatic test_decode();
    logic [1:0] v_op  [13] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2,
                               2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};
    logic [5:0] v_fn  [13] = '{6'b000000, 6'b100000, 6'b000000, 6'b100000, 6'b100010,
                               6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b000000,
                               6'b000010, 6'b011000, 6'b011000};
    logic [3:0] v_exp [13] = '{4'd2, 4'd5, 4'd7, 4'd2, 4'd5, 4'd0, 4'd1,
                               4'd12, 4'd7, 4'd3, 4'd4, 4'd5, 4'd2};
    for (int i = 0; i < 13; i++) begin
      step();
      valid = 1'b1; flush = 1'b0; alu_op = v_op[i]; funct = v_fn[i];
      @(negedge clk);
      n_cmp++; if (a_alu !== v_exp[i]) begin n_err++; $display("FAIL decode[%0d] alu_control: got %0d want %0d", i, a_alu, v_exp[i]); end
      n_cmp++; if (a_stall !== 1'b0 || a_start !== 1'b0) begin n_err++; $display("FAIL decode[%0d] stall/start: got %b/%b want 0/0", i, a_stall, a_start); end
      n_cmp++; if (a_we !== 1'b0) begin n_err++; $display("FAIL decode[%0d] hilo_we: got %b want 0", i, a_we); end
    end
    go_idle(2);
  endtask

  // 4-cycle MULT: start@0, stall@0..3, hilo_we@4 only; valid dropped while BUSY.
  task automatic test_mult4();
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) begin valid = 1'b1; flush = 1'b0; alu_op = 2'd2; funct = F_MULT; end
      if (c == 1) valid = 1'b0;
      if (c == 5) alu_op = 2'd0;
      @(negedge clk);
      n_cmp++; if (a_start !== (c == 0)) begin n_err++; $display("FAIL mult4 start c=%0d: got %b want %b", c, a_start, c == 0); end
      n_cmp++; if (a_stall !== (c < 4)) begin n_err++; $display("FAIL mult4 stall c=%0d: got %b want %b", c, a_stall, c < 4); end
      n_cmp++; if (a_we !== (c == 4)) begin n_err++; $display("FAIL mult4 hilo_we c=%0d: got %b want %b", c, a_we, c == 4); end
      n_cmp++; if (a_alu !== ((c < 5) ? 4'd14 : 4'd2)) begin n_err++; $display("FAIL mult4 alu c=%0d: got %0d want %0d", c, a_alu, (c < 5) ? 14 : 2); end
      n_cmp++; if (b_we !== (c == 1)) begin n_err++; $display("FAIL mult1 single hilo_we c=%0d: got %b want %b", c, b_we, c == 1); end
    end
    go_idle(2);
  endtask

  // 1-cycle MULT held on the inputs: start, DONE, start again right after DONE, DONE.
  task automatic test_back_to_back();
    for (int c = 0; c < 5; c++) begin
      step();
      if (c == 0) begin valid = 1'b1; flush = 1'b0; alu_op = 2'd2; funct = F_MULT; end
      if (c == 4) begin valid = 1'b0; alu_op = 2'd0; end
      @(negedge clk);
      n_cmp++; if (b_start !== (c == 0 || c == 2)) begin n_err++; $display("FAIL b2b start c=%0d: got %b want %b", c, b_start, c == 0 || c == 2); end
      n_cmp++; if (b_stall !== (c == 0 || c == 2)) begin n_err++; $display("FAIL b2b stall c=%0d: got %b want %b", c, b_stall, c == 0 || c == 2); end
      n_cmp++; if (b_we !== (c == 1 || c == 3)) begin n_err++; $display("FAIL b2b hilo_we c=%0d: got %b want %b", c, b_we, c == 1 || c == 3); end
      n_cmp++; if (b_alu !== ((c < 4) ? 4'd14 : 4'd2)) begin n_err++; $display("FAIL b2b alu c=%0d: got %0d want %0d", c, b_alu, (c < 4) ? 14 : 2); end
    end
    go_idle(3);
  endtask

  task automatic test_flush();
    // Flush together with a would-be start: nothing launches.
    step();
    valid = 1'b1; flush = 1'b1; alu_op = 2'd2; funct = F_MULT;
    @(negedge clk);
    n_cmp++; if (a_start !== 1'b0 || a_stall !== 1'b0) begin n_err++; $display("FAIL flush_start start/stall: got %b/%b want 0/0", a_start, a_stall); end
    step();
    valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_stall !== 1'b0 || a_alu !== 4'd14) begin n_err++; $display("FAIL flush_start after: stall=%b alu=%0d want 0/14", a_stall, a_alu); end
    go_idle(1);
    // Flush in the second BUSY cycle.
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) begin valid = 1'b1; flush = 1'b0; alu_op = 2'd2; funct = F_MULT; end
      if (c == 2) flush = 1'b1;
      if (c == 3) begin flush = 1'b0; valid = 1'b0; alu_op = 2'd0; end
      @(negedge clk);
      n_cmp++; if (a_stall !== (c < 3)) begin n_err++; $display("FAIL flush_busy stall c=%0d: got %b want %b", c, a_stall, c < 3); end
      n_cmp++; if (a_we !== 1'b0) begin n_err++; $display("FAIL flush_busy hilo_we c=%0d: got %b want 0", c, a_we); end
      if (c >= 3) begin
        n_cmp++; if (a_alu !== 4'd2) begin n_err++; $display("FAIL flush_busy alu c=%0d: got %0d want 2", c, a_alu); end
      end
    end
    go_idle(2);
  endtask

  task automatic test_arst();
    step();
    valid = 1'b1; flush = 1'b0; alu_op = 2'd2; funct = F_MULT;
    step();
    valid = 1'b0;
    step();
    n_cmp++; if (a_stall !== 1'b1) begin n_err++; $display("FAIL arst pre stall: got %b want 1", a_stall); end
    arst = 1'b1; alu_op = 2'd0;
    #1;
    n_cmp++; if (a_stall !== 1'b0 || a_we !== 1'b0) begin n_err++; $display("FAIL arst immediate stall/we: got %b/%b want 0/0", a_stall, a_we); end
    n_cmp++; if (a_alu !== 4'd2) begin n_err++; $display("FAIL arst immediate alu: got %0d want 2", a_alu); end
    n_cmp++; if (a_ill !== 1'b0) begin n_err++; $display("FAIL arst illegal_funct: got %b want 0", a_ill); end
    @(negedge clk);
    arst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      @(negedge clk);
      n_cmp++; if (a_we !== 1'b0 || a_stall !== 1'b0) begin n_err++; $display("FAIL arst after c=%0d we/stall: got %b/%b want 0/0", c, a_we, a_stall); end
    end
    go_idle(1);
  endtask

  task automatic test_illegal();
    step();
    valid = 1'b0; flush = 1'b0; alu_op = 2'd2; funct = F_BAD;
    @(negedge clk);
    n_cmp++; if (a_alu !== 4'd0) begin n_err++; $display("FAIL illegal decode alu: got %0d want 0", a_alu); end
    step();
    valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (a_ill !== 1'b0) begin n_err++; $display("FAIL illegal not yet set: got %b want 0", a_ill); end
    n_cmp++; if (a_alu !== 4'd0 || a_stall !== 1'b0) begin n_err++; $display("FAIL illegal alu/stall: got %0d/%b want 0/0", a_alu, a_stall); end
    step();
    valid = 1'b0; alu_op = 2'd0; funct = 6'd0;
    @(negedge clk);
    n_cmp++; if (a_ill !== EXP_ILL) begin n_err++; $display("FAIL illegal set: got %b want %b", a_ill, EXP_ILL); end
    go_idle(3);
    @(negedge clk);
    n_cmp++; if (a_ill !== EXP_ILL) begin n_err++; $display("FAIL illegal sticky: got %b want %b", a_ill, EXP_ILL); end
    step();
    arst = 1'b1;
    #1;
    n_cmp++; if (a_ill !== 1'b0) begin n_err++; $display("FAIL illegal cleared by arst: got %b want 0", a_ill); end
    @(negedge clk);
    arst = 1'b0;
    go_idle(1);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mult4();
    test_back_to_back();
    test_flush();
    test_arst();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
